// File: rtl/pipe_wb_regfile_if.sv
// WB-stage bus between the MEM/WB pipeline register, the register file and the ID stage.
// The master drives the WB controls and read addresses; the slave (the register file) returns the read and WB data.
interface pipe_wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] wmo;
    logic [DW-1:0] walu;
    logic [AW-1:0] wrn;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] wdata;

    modport master (
        output wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
        input  qa, qb, wdata
    );

    modport slave (
        input  wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
        output qa, qb, wdata
    );
endinterface

// File: rtl/pipe_wb_regfile.sv
// Write-back stage plus 32-entry GPR file with two combinational read ports.
// Define REGFILE_BYPASS_EN to have a read of the register being written return the new WB value in the same cycle.
module pipe_wb_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 2**AW
) (
    input  logic               clk,
    input  logic               rst,
    pipe_wb_regfile_if.slave   bus
);
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wr_en;

    assign bus.wdata = bus.wm2reg ? bus.wmo : bus.walu;
    assign wr_en     = !rst && bus.wwreg && (bus.wrn != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wrn] = bus.wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through: the register being written is seen with its new value in the same cycle.
    always_comb begin
        if (bus.rna == '0) begin
            bus.qa = '0;
        end else if (wr_en && (bus.rna == bus.wrn)) begin
            bus.qa = bus.wdata;
        end else begin
            bus.qa = regs_q[bus.rna];
        end
        if (bus.rnb == '0) begin
            bus.qb = '0;
        end else if (wr_en && (bus.rnb == bus.wrn)) begin
            bus.qb = bus.wdata;
        end else begin
            bus.qb = regs_q[bus.rnb];
        end
    end
`else
    always_comb begin
        bus.qa = (bus.rna == '0) ? '0 : regs_q[bus.rna];
        bus.qb = (bus.rnb == '0) ? '0 : regs_q[bus.rnb];
    end
`endif

endmodule
